// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Frequency-sweep sequencer for a downstream DDS. On an accepted Start the
// sweep configuration is captured into shadow registers, then Fword walks
// from the start word towards the stop word in Step_Fword increments. Each
// point is held for max(Dwell,1) clocks. The final point is always exactly
// the stop word: an overshoot or a carry out of FW_W bits clamps to it. In
// continuous mode the sweep restarts at the start word indefinitely. In
// single mode it ends with a one-cycle Done pulse.
//
// Ports
//   Clk          system clock, rising edge
//   Rst          synchronous active-high reset
//   Start        one-cycle sweep request (ignored while Busy)
//   Abort        one-cycle abort request (ends an active sweep immediately)
//   Mode         0 = single sweep, 1 = continuous
//   Start_Fword  first frequency word
//   Stop_Fword   final frequency word
//   Step_Fword   frequency-word increment per point
//   Dwell        clocks per point (0 behaves as 1)
//   Pword_in     phase offset for the sweep
//   Fword        registered frequency word to the DDS
//   Pword        registered phase word to the DDS
//   Busy         high while a sweep is active
//   Step_Strobe  one-cycle pulse in the cycle Fword takes a new point
//   Done         one-cycle pulse when a single sweep completes
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
   parameter int FW_W = 32,
   parameter int PW_W = 12,
   parameter int DW_W = 24
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            Start,
   input  logic            Abort,
   input  logic            Mode,
   input  logic [FW_W-1:0] Start_Fword,
   input  logic [FW_W-1:0] Stop_Fword,
   input  logic [FW_W-1:0] Step_Fword,
   input  logic [DW_W-1:0] Dwell,
   input  logic [PW_W-1:0] Pword_in,
   output logic [FW_W-1:0] Fword,
   output logic [PW_W-1:0] Pword,
   output logic            Busy,
   output logic            Step_Strobe,
   output logic            Done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DWELL,   // holding an intermediate point
      ST_LAST     // holding the final point
   } state_e;

   state_e          state_q, state_d;
   logic [FW_W-1:0] fword_q, fword_d;
   logic [PW_W-1:0] pword_q, pword_d;
   logic            strobe_q, strobe_d;
   logic            done_q, done_d;
   logic [DW_W-1:0] cnt_q, cnt_d;

   // Shadow copy of the configuration; live inputs are ignored mid-sweep.
   logic [FW_W-1:0] sh_start_q, sh_start_d;
   logic [FW_W-1:0] sh_stop_q, sh_stop_d;
   logic [FW_W-1:0] sh_step_q, sh_step_d;
   logic [DW_W-1:0] sh_dwell_q, sh_dwell_d;
   logic            sh_mode_q, sh_mode_d;

   // Next point computed one bit wider so a carry is seen, not wrapped.
   logic [FW_W:0]   next_fw;

   // Remaining-cycles value loaded on a strobe; counts down to zero, so a
   // point lasts (load + 1) cycles including the strobe cycle.
   function automatic logic [DW_W-1:0] hold_count(input logic [DW_W-1:0] dwell);
      return (dwell == '0) ? '0 : dwell - DW_W'(1);
   endfunction

   // A sweep with no forward progress collapses to a single (final) point.
   function automatic logic is_single_point(input logic [FW_W-1:0] f_start,
                                            input logic [FW_W-1:0] f_stop,
                                            input logic [FW_W-1:0] f_step);
      return (f_start >= f_stop) || (f_step == '0);
   endfunction

   assign next_fw = {1'b0, fword_q} + {1'b0, sh_step_q};

   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves one unassigned, which would infer a latch.
      state_d    = state_q;
      fword_d    = fword_q;
      pword_d    = pword_q;
      strobe_d   = 1'b0;
      done_d     = 1'b0;
      cnt_d      = cnt_q;
      sh_start_d = sh_start_q;
      sh_stop_d  = sh_stop_q;
      sh_step_d  = sh_step_q;
      sh_dwell_d = sh_dwell_q;
      sh_mode_d  = sh_mode_q;

      case (state_q)
         ST_IDLE: begin
            // Start together with Abort starts nothing.
            if (Start && !Abort) begin
               sh_start_d = Start_Fword;
               sh_stop_d  = Stop_Fword;
               sh_step_d  = Step_Fword;
               sh_dwell_d = Dwell;
               sh_mode_d  = Mode;
               fword_d    = Start_Fword;
               pword_d    = Pword_in;
               strobe_d   = 1'b1;
               cnt_d      = hold_count(Dwell);
               state_d    = is_single_point(Start_Fword, Stop_Fword, Step_Fword)
                            ? ST_LAST : ST_DWELL;
            end
         end

         ST_DWELL, ST_LAST: begin
            if (Abort) begin
               // Words hold; no strobe and no Done on an abort.
               state_d = ST_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DW_W'(1);
            end else if (state_q == ST_DWELL) begin
               strobe_d = 1'b1;
               cnt_d    = hold_count(sh_dwell_q);
               if (next_fw[FW_W] || (next_fw >= {1'b0, sh_stop_q})) begin
                  fword_d = sh_stop_q;
                  state_d = ST_LAST;
               end else begin
                  fword_d = next_fw[FW_W-1:0];
               end
            end else if (sh_mode_q) begin
               // Continuous: restart from the captured start word.
               fword_d  = sh_start_q;
               strobe_d = 1'b1;
               cnt_d    = hold_count(sh_dwell_q);
               state_d  = is_single_point(sh_start_q, sh_stop_q, sh_step_q)
                          ? ST_LAST : ST_DWELL;
            end else begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         // NOTE: the shadow configuration is reset as well, so a fresh sweep
         // never observes stale values from before the reset.
         state_q    <= ST_IDLE;
         fword_q    <= '0;
         pword_q    <= '0;
         strobe_q   <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= '0;
         sh_start_q <= '0;
         sh_stop_q  <= '0;
         sh_step_q  <= '0;
         sh_dwell_q <= '0;
         sh_mode_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fword_q    <= fword_d;
         pword_q    <= pword_d;
         strobe_q   <= strobe_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
         sh_start_q <= sh_start_d;
         sh_stop_q  <= sh_stop_d;
         sh_step_q  <= sh_step_d;
         sh_dwell_q <= sh_dwell_d;
         sh_mode_q  <= sh_mode_d;
      end
   end

   assign Fword       = fword_q;
   assign Pword       = pword_q;
   assign Busy        = (state_q != ST_IDLE);
   assign Step_Strobe = strobe_q;
   assign Done        = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//
// Self-checking bench for dds_sweep_ctrl. A reference model turns each
// accepted sweep into a list of points plus an elapsed-cycle count and
// predicts every output on every cycle. Directed scenarios pin the model and
// the design with hand-computed literal values. A randomized phase follows,
// with random config churn, Start/Abort pulses and occasional resets.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

   localparam int FW_W = 32;
   localparam int PW_W = 12;
   localparam int DW_W = 24;

   logic            Clk = 1'b0;
   logic            Rst, Start, Abort, Mode;
   logic [FW_W-1:0] Start_Fword, Stop_Fword, Step_Fword;
   logic [DW_W-1:0] Dwell;
   logic [PW_W-1:0] Pword_in;
   logic [FW_W-1:0] Fword;
   logic [PW_W-1:0] Pword;
   logic            Busy, Step_Strobe, Done;

   dds_sweep_ctrl #(.FW_W(FW_W), .PW_W(PW_W), .DW_W(DW_W)) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Start       (Start),
      .Abort       (Abort),
      .Mode        (Mode),
      .Start_Fword (Start_Fword),
      .Stop_Fword  (Stop_Fword),
      .Step_Fword  (Step_Fword),
      .Dwell       (Dwell),
      .Pword_in    (Pword_in),
      .Fword       (Fword),
      .Pword       (Pword),
      .Busy        (Busy),
      .Step_Strobe (Step_Strobe),
      .Done        (Done)
   );

   always #5 Clk = ~Clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: a sweep is a list of point values; each point lasts
   // dwell cycles; the outputs follow from elapsed cycles since acceptance.
   // ---------------------------------------------------------------------
   bit              m_ready = 1'b0;
   bit              m_act   = 1'b0;
   bit              m_mode;
   int              m_dd, m_k;
   logic [FW_W-1:0] m_pts[$];
   logic [FW_W-1:0] e_fw;
   logic [PW_W-1:0] e_pw;
   logic            e_busy, e_stb, e_done;

   function automatic void build_points(input logic [FW_W-1:0] s,
                                        input logic [FW_W-1:0] p,
                                        input logic [FW_W-1:0] st);
      longint unsigned v;
      m_pts.delete();
      if (s >= p || st == 0) begin
         m_pts.push_back(s);
      end else begin
         v = longint'(s);
         while (v < longint'(p)) begin
            m_pts.push_back(v[FW_W-1:0]);
            v = v + longint'(st);
         end
         m_pts.push_back(p);
      end
   endfunction

   always @(posedge Clk) begin
      if (Rst) begin
         m_ready = 1'b1;
         m_act   = 1'b0;
         e_fw    = '0;
         e_pw    = '0;
         e_busy  = 1'b0;
         e_stb   = 1'b0;
         e_done  = 1'b0;
      end else if (m_ready) begin
         e_stb  = 1'b0;
         e_done = 1'b0;
         if (!m_act) begin
            if (Start && !Abort) begin
               build_points(Start_Fword, Stop_Fword, Step_Fword);
               m_dd   = (Dwell == 0) ? 1 : int'(Dwell);
               m_mode = Mode;
               m_k    = 0;
               m_act  = 1'b1;
               e_fw   = m_pts[0];
               e_pw   = Pword_in;
               e_busy = 1'b1;
               e_stb  = 1'b1;
            end
         end else if (Abort) begin
            m_act  = 1'b0;
            e_busy = 1'b0;
         end else begin
            m_k++;
            if (m_k == m_pts.size() * m_dd) begin
               if (m_mode) begin
                  m_k = 0;
               end else begin
                  m_act  = 1'b0;
                  e_busy = 1'b0;
                  e_done = 1'b1;
               end
            end
            if (m_act && (m_k % m_dd == 0)) begin
               e_stb = 1'b1;
               e_fw  = m_pts[m_k / m_dd];
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge Clk) begin
      if (m_ready) begin
         check("fword",  Fword,       e_fw);
         check("pword",  Pword,       e_pw);
         check("busy",   Busy,        e_busy);
         check("strobe", Step_Strobe, e_stb);
         check("done",   Done,        e_done);
      end
   end

   // Monitor recording what the directed scenarios check literally.
   int              ncyc = 0;
   logic [FW_W-1:0] slog[$];
   int              busy_cnt, done_cnt, first_cyc, done_cyc;

   always @(negedge Clk) begin
      ncyc++;
      if (Step_Strobe === 1'b1) begin
         slog.push_back(Fword);
         if (first_cyc < 0) first_cyc = ncyc;
      end
      if (Busy === 1'b1) busy_cnt++;
      if (Done === 1'b1) begin
         done_cnt++;
         done_cyc = ncyc;
      end
   end

   task automatic clear_log();
      slog.delete();
      busy_cnt  = 0;
      done_cnt  = 0;
      first_cyc = -1;
      done_cyc  = -1;
   endtask

   task automatic check_log(input string tag, input logic [FW_W-1:0] exp[$]);
      check({tag, "_npts"}, slog.size(), exp.size());
      foreach (exp[i])
         if (i < slog.size()) check($sformatf("%s_pt%0d", tag, i), slog[i], exp[i]);
   endtask

   task automatic start_sweep(input logic [FW_W-1:0] s, input logic [FW_W-1:0] p,
                              input logic [FW_W-1:0] st, input int dw, input bit md,
                              input logic [PW_W-1:0] pw);
      Start_Fword = s;
      Stop_Fword  = p;
      Step_Fword  = st;
      Dwell       = DW_W'(dw);
      Mode        = md;
      Pword_in    = pw;
      Start       = 1'b1;
      @(negedge Clk);
      Start       = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge Clk);
         if (Done === 1'b1) seen = 1'b1;
      end
      if (!seen) check({tag, "_done_timeout"}, 0, 1);
      @(negedge Clk);
   endtask

   // Configuration kept in ranges that bound the number of points per sweep.
   task automatic rand_cfg();
      if ($urandom % 6 == 0) begin
         Start_Fword = 32'hFFFF_F000 + $urandom_range(0, 'h800);
         Stop_Fword  = 32'hFFFF_F800 + $urandom_range(0, 'h7FF);
         Step_Fword  = $urandom_range('h100, 'h900);
      end else begin
         Start_Fword = $urandom_range(0, 2000);
         Stop_Fword  = ($urandom % 5 == 0) ? $urandom_range(0, 2000)
                                           : Start_Fword + $urandom_range(0, 2000);
         Step_Fword  = ($urandom % 8 == 0) ? 0 : $urandom_range(150, 800);
      end
      Dwell    = DW_W'($urandom_range(0, 4));
      Mode     = ($urandom % 4 == 0);
      Pword_in = PW_W'($urandom);
   endtask

   logic [FW_W-1:0] exp_q[$];

   initial begin
      int cnt20;
      Rst = 1'b1; Start = 1'b0; Abort = 1'b0; Mode = 1'b0;
      Start_Fword = '0; Stop_Fword = '0; Step_Fword = '0; Dwell = '0; Pword_in = '0;
      clear_log();
      repeat (3) @(negedge Clk);
      check("rst_fword", Fword, 0);
      check("rst_busy",  Busy,  0);
      Rst = 1'b0;
      @(negedge Clk);

      // Single sweep, with a Start and config churn while busy.
      clear_log();
      start_sweep(100, 400, 100, 3, 1'b0, 12'h123);
      check("single_pword", Pword, 12'h123);
      repeat (2) @(negedge Clk);
      Start_Fword = 7; Stop_Fword = 9000; Step_Fword = 1; Dwell = 0; Mode = 1'b1;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      wait_done(100, "single");
      exp_q = '{32'd100, 32'd200, 32'd300, 32'd400};
      check_log("single", exp_q);
      check("single_busy_cycles", busy_cnt, 12);
      check("single_done_delay", done_cyc - first_cyc, 12);
      check("single_hold_stop", Fword, 400);

      // Clamp at the stop word, Dwell 0 behaving as 1.
      clear_log();
      start_sweep(0, 250, 100, 0, 1'b0, 12'h0);
      wait_done(50, "clamp");
      exp_q = '{32'd0, 32'd100, 32'd200, 32'd250};
      check_log("clamp", exp_q);
      check("clamp_done_delay", done_cyc - first_cyc, 4);

      // Carry out of the word width must clamp, not wrap.
      clear_log();
      start_sweep(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 2, 1'b0, 12'h0);
      wait_done(50, "ovf");
      exp_q = '{32'hFFFF_FF00, 32'hFFFF_FFFF};
      check_log("ovf", exp_q);

      // Degenerate sweeps: start equals stop, then a zero step.
      clear_log();
      start_sweep(500, 500, 100, 4, 1'b0, 12'h0);
      wait_done(50, "degen_eq");
      exp_q = '{32'd500};
      check_log("degen_eq", exp_q);
      check("degen_eq_done_delay", done_cyc - first_cyc, 4);
      clear_log();
      start_sweep(500, 900, 0, 4, 1'b0, 12'h0);
      wait_done(50, "degen_step0");
      check_log("degen_step0", exp_q);
      check("degen_step0_done_delay", done_cyc - first_cyc, 4);

      // Start and Abort together in idle start nothing.
      Start = 1'b1; Abort = 1'b1;
      @(negedge Clk);
      Start = 1'b0; Abort = 1'b0;
      check("start_abort_busy", Busy, 0);
      check("start_abort_strobe", Step_Strobe, 0);

      // Continuous sweep, aborted on the second visit to 20.
      clear_log();
      start_sweep(10, 30, 10, 1, 1'b1, 12'h055);
      cnt20 = 0;
      for (int i = 0; i < 50 && cnt20 < 2; i++) begin
         if (Step_Strobe === 1'b1 && Fword == 20) cnt20++;
         if (cnt20 < 2) @(negedge Clk);
      end
      check("cont_reached_second_20", cnt20, 2);
      Abort = 1'b1;
      @(negedge Clk);
      Abort = 1'b0;
      check("cont_abort_busy", Busy, 0);
      check("cont_abort_fword", Fword, 20);
      check("cont_abort_strobe", Step_Strobe, 0);
      @(negedge Clk);
      exp_q = '{32'd10, 32'd20, 32'd30, 32'd10, 32'd20};
      check_log("cont", exp_q);
      check("cont_no_done", done_cnt, 0);

      // Reset mid-sweep, then Start on the first edge after it.
      start_sweep(100, 1000, 100, 5, 1'b0, 12'h0AA);
      repeat (7) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      check("midrst_fword", Fword, 0);
      check("midrst_pword", Pword, 0);
      check("midrst_busy", Busy, 0);
      Rst = 1'b0;
      start_sweep(300, 600, 150, 2, 1'b0, 12'h321);
      check("post_rst_fword", Fword, 300);
      check("post_rst_pword", Pword, 12'h321);
      check("post_rst_strobe", Step_Strobe, 1);
      wait_done(50, "post_rst");

      // Randomized phase: the per-cycle model comparison does the checking.
      for (int it = 0; it < 60; it++) begin
         int lim;
         rand_cfg();
         Start = 1'b1;
         @(negedge Clk);
         lim = Mode ? int'($urandom_range(20, 80)) : 600;
         for (int c = 0; c < lim; c++) begin
            Start = ($urandom % 25 == 0);
            Abort = ($urandom % 60 == 0);
            Rst   = ($urandom % 300 == 0);
            rand_cfg();
            @(negedge Clk);
            if (Busy !== 1'b1) break;
         end
         Start = 1'b0; Rst = 1'b0; Abort = 1'b1;
         @(negedge Clk);
         Abort = 1'b0;
         repeat (2) @(negedge Clk);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1);
   end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter FW_W, 32, frequency-word width.
REQ-002 Parameter PW_W, 12, phase-word width.
REQ-003 Parameter DW_W, 24, dwell-counter width.
REQ-004 Clk  input  1  system clock; all logic on rising edge.
REQ-005 Rst  input  1  reset, synchronous, active-high.
REQ-006 Start  input  1  single-cycle sweep start request.
REQ-007 Abort  input  1  single-cycle sweep abort request.
REQ-008 Mode  input  1  0 = single sweep, 1 = continuous, restarting at start word.
REQ-009 Start_Fword  input  FW_W  first frequency word.
REQ-010 Stop_Fword  input  FW_W  final frequency word.
REQ-011 Step_Fword  input  FW_W  frequency-word increment per point.
REQ-012 Dwell  input  DW_W  Clk cycles each point is held; 0 is treated as 1.
REQ-013 Pword_in  input  PW_W  phase offset for the sweep.
REQ-014 Fword  output  FW_W  registered frequency word driving the downstream DDS phase accumulator.
REQ-015 Pword  output  PW_W  registered phase word driving the downstream DDS.
REQ-016 Busy  output  1  high while a sweep is active.
REQ-017 Step_Strobe  output  1  one-cycle pulse in the cycle Fword takes a new point value.
REQ-018 Done  output  1  one-cycle pulse when a single sweep completes.

Function
REQ-019 The FSM SHALL have states IDLE, DWELL (intermediate point) and LAST (final point).
REQ-020 In IDLE, Start sampled high at edge N SHALL latch Start/Stop/Step/Dwell/Mode/Pword_in into shadow registers.
  - Cycle N+1: Fword = Start_Fword, Pword = Pword_in, Busy = 1, Step_Strobe = 1.
REQ-021 Changes on configuration inputs while Busy SHALL have no effect until the next accepted Start.
REQ-022 Start while Busy SHALL be ignored.
REQ-023 On Start, if Start_Fword >= Stop_Fword or Step_Fword == 0, the FSM SHALL enter LAST; otherwise it SHALL enter DWELL.
REQ-024 Each point SHALL be held for exactly max(Dwell,1) cycles, counted from the Step_Strobe cycle inclusive.
REQ-025 At the end of a DWELL point, next = Fword + Step_Fword SHALL be computed at FW_W+1 bits.
  - If carry = 1 or next >= Stop_Fword: Fword = Stop_Fword, enter LAST.
  - Otherwise: Fword = next[FW_W-1:0], remain in DWELL.
  - Step_Strobe = 1 in either case.
REQ-026 At the end of LAST with Mode = 0, the FSM SHALL pulse Done for one cycle, drop Busy in that same cycle, enter IDLE, and hold Fword at Stop_Fword.
REQ-027 At the end of LAST with Mode = 1, the FSM SHALL reload Fword = shadow start word with Step_Strobe = 1, keep Busy high, emit no Done, and apply REQ-023 using the shadow values.
REQ-028 Abort while Busy SHALL force IDLE at the next edge.
  - Busy = 0; Fword and Pword hold their current values.
  - No Done or Step_Strobe is emitted.
  - Abort takes priority over any point transition in the same cycle.
REQ-029 Start and Abort high together in IDLE SHALL leave the block in IDLE with no sweep started.
REQ-030 Fword and Pword SHALL change only on a Step_Strobe cycle (REQ-020) or on reset, so the downstream phase accumulator sees glitch-free words.

Reset
REQ-031 Rst high at a clock edge SHALL set state = IDLE, Fword = 0, Pword = 0, Busy = 0, Step_Strobe = 0, Done = 0, dwell counter = 0, shadow registers = 0.
REQ-032 Rst SHALL override Start and Abort, and SHALL take effect even mid-sweep.
REQ-033 After Rst deasserts, the block SHALL accept Start on the first following edge.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - Single sweep: Start = 100, Stop = 400, Step = 100, Dwell = 3, Mode = 0 -> Fword 100, 200, 300, 400, each held 3 cycles; 4 Step_Strobe pulses; Done 12 cycles after the first strobe; Busy high for exactly 12 cycles.
  - Clamp: Start = 0, Stop = 250, Step = 100, Dwell = 0 -> Fword 0, 100, 200, 250, one cycle each; Done the cycle after 250.
  - Overflow: Start = 0xFFFF_FF00, Stop = 0xFFFF_FFFF, Step = 0x200, Dwell = 2 -> Fword 0xFFFF_FF00, then 0xFFFF_FFFF; never wraps to a small value.
  - Degenerate: Start = Stop = 500, or Step = 0, with Dwell = 4 -> single point 500 held 4 cycles, then Done.
  - Continuous: Mode = 1, Start = 10, Stop = 30, Step = 10, Dwell = 1 -> Fword repeats 10, 20, 30, 10, ...; Busy stays 1; no Done; Abort at the second 20 -> Busy = 0 next cycle and Fword holds 20.
  - Reset mid-sweep: Rst pulsed during a DWELL point -> all outputs 0 next edge; Start on the following edge begins a fresh sweep per REQ-020.
